// File: rtl/bcd_display_driver.sv
// Purpose: latch the 8-bit result on entry to display phase, convert it to 3 BCD digits (double-dabble), scan a 3-digit 7-seg display.
// Latency: 8 clocks from the edge that samples phase==3 to bcd valid / done pulse; display scanning starts on that same edge.
// Backpressure: none; phase is a level and leaving display phase aborts conversion or scanning on the next edge.
module bcd_display_driver #(
    parameter int DIGIT_REFRESH = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  phase,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int RW = (DIGIT_REFRESH > 1) ? $clog2(DIGIT_REFRESH) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(DIGIT_REFRESH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            in_s3;
    logic [7:0]      shift_q;
    logic [3:0]      hund_q;
    logic [3:0]      tens_q;
    logic [3:0]      ones_q;
    logic [2:0]      bit_cnt;
    logic [RW-1:0]   refresh_cnt;
    logic [1:0]      scan_idx;
    logic            last_shift;

    logic [3:0]      hund_adj;
    logic [3:0]      tens_adj;
    logic [3:0]      ones_adj;
    logic [19:0]     dabble;

    assign in_s3      = (phase == 2'd3);
    assign last_shift = (bit_cnt == 3'd7);

    // 4-bit add-3 correction; the hundreds digit stays below 5 for 8-bit input, so no carry is ever needed.
    assign hund_adj = (hund_q >= 4'd5) ? hund_q + 4'd3 : hund_q;
    assign tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
    assign ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
    assign dabble   = {hund_adj, tens_adj, ones_adj, shift_q} << 1;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter conversion on phase 3, any other phase drops straight back to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_s3) state_nxt = CONV;
            CONV:    if (!in_s3) state_nxt = IDLE;
                     else if (last_shift) state_nxt = SHOW;
            SHOW:    if (!in_s3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion engine, result register and scan counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q     <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            bit_cnt     <= '0;
            refresh_cnt <= '0;
            scan_idx    <= '0;
            bcd         <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_s3) begin
                        shift_q <= data_in;
                        hund_q  <= '0;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        bit_cnt <= '0;
                    end
                    refresh_cnt <= '0;
                    scan_idx    <= '0;
                    bcd         <= '0;
                end
                CONV: begin
                    if (!in_s3) begin
                        // Abort wins over a coinciding last shift: nothing is published.
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        hund_q  <= dabble[19:16];
                        tens_q  <= dabble[15:12];
                        ones_q  <= dabble[11:8];
                        shift_q <= dabble[7:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_shift) begin
                            bcd  <= dabble[19:8];
                            done <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (!in_s3) begin
                        bcd         <= '0;
                        refresh_cnt <= '0;
                        scan_idx    <= '0;
                    end else if (refresh_cnt == REFRESH_LAST) begin
                        refresh_cnt <= '0;
                        scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
                    end else begin
                        refresh_cnt <= refresh_cnt + RW'(1);
                    end
                end
                default: begin
                    bcd <= '0;
                end
            endcase
        end
    end

    // Display outputs: one-hot digit enable with leading-zero blanking on tens and hundreds.
    always_comb begin
        busy = (state == CONV);
        an   = 3'b000;
        seg  = 7'b0000000;
        if (state == SHOW) begin
            case (scan_idx)
                2'd0: begin
                    an  = 3'b001;
                    seg = seg_decode(bcd[3:0]);
                end
                2'd1: begin
                    an  = 3'b010;
                    seg = (bcd[11:4] == 8'd0) ? 7'b0000000 : seg_decode(bcd[7:4]);
                end
                2'd2: begin
                    an  = 3'b100;
                    seg = (bcd[11:8] == 4'd0) ? 7'b0000000 : seg_decode(bcd[11:8]);
                end
                default: begin
                    an  = 3'b000;
                    seg = 7'b0000000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Purpose: randomized and directed stimulus for bcd_display_driver against an arithmetic reference model.
// Latency: expects done 8 clocks after phase==3 is sampled, scanning with a 2-cycle digit refresh.
// Backpressure: n/a; a queue of expected bcd values is drained by a monitor on each done pulse.
module tb_bcd_display_driver;

    localparam int DR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  phase = 2'd0;
    logic [7:0]  data_in = 8'd0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    logic        prev_done = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    bcd_display_driver #(.DIGIT_REFRESH(DR)) dut (
        .clk     (clk),
        .rst     (rst),
        .phase   (phase),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // idx 0=ones, 1=tens, 2=hundreds; values below 10 / 100 hide the leading digits.
    function automatic logic [6:0] model_seg(input int v, input int idx);
        int d;
        if (idx == 2 && v < 100) return 7'd0;
        if (idx == 1 && v < 10)  return 7'd0;
        d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
        return seg_tab[d];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bcd"},  bcd,  0);
        check({tag, "_seg"},  seg,  0);
        check({tag, "_an"},   an,   0);
    endtask

    // Start a conversion from IDLE and measure busy length and done latency.
    task automatic run_conv(input int v);
        int n;
        int busy_cnt;
        bit seen;
        data_in = 8'(v);
        phase   = 2'd3;
        exp_q.push_back(model_bcd(v));
        n = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        check("done_latency", n, 9);
        check("busy_cycles", busy_cnt, 8);
        check("busy_at_done", busy, 0);
        check("first_an", an, 3'b001);
        check("first_seg", seg, model_seg(v, 0));
    endtask

    // Cycle 0 of scanning was checked by run_conv; follow the scan for ncyc cycles.
    task automatic check_scan(input int v, input int ncyc);
        int idx;
        for (int c = 1; c < ncyc; c++) begin
            tick();
            idx = (c / DR) % 3;
            check("scan_an", an, 32'(1) << idx);
            check("scan_seg", seg, model_seg(v, idx));
        end
        check("show_bcd", bcd, model_bcd(v));
    endtask

    task automatic leave();
        phase = 2'd0;
        tick();
        check_idle("leave");
    endtask

    // Scoreboard monitor: each done pulse consumes one expected bcd value.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: bcd=%h with no conversion outstanding at %0t", bcd, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_bcd", bcd, mon_exp);
            end
            check("done_single_cycle", {prev_done, done}, 2'b01);
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int directed [6] = '{107, 0, 9, 10, 99, 100};
        int v;

        // Reset held with phase already at 3: nothing may start.
        phase   = 2'd3;
        data_in = 8'd255;
        repeat (3) tick();
        check_idle("reset");

        rst = 1'b1;
        run_conv(255);
        check_scan(255, 13);
        data_in = 8'd17;
        repeat (4) tick();
        check("bcd_hold_data_change", bcd, model_bcd(255));
        leave();

        foreach (directed[i]) begin
            run_conv(directed[i]);
            check_scan(directed[i], 13);
            leave();
        end

        // Abort on the 4th conversion cycle, then re-enter with a fresh value.
        data_in = 8'd200;
        phase   = 2'd3;
        repeat (4) tick();
        check("abort_busy_before", busy, 1);
        phase = 2'd0;
        tick();
        check_idle("abort4");
        repeat (10) tick();
        check("abort4_still_idle", {busy, an}, 4'b0000);
        run_conv(42);
        check_scan(42, 7);
        leave();

        // Abort on the same edge as the 8th shift.
        data_in = 8'd123;
        phase   = 2'd3;
        repeat (8) tick();
        phase = 2'd0;
        tick();
        check_idle("abort_last");
        repeat (3) tick();

        // Asynchronous reset while scanning.
        run_conv(231);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        #2;
        phase = 2'd0;
        tick();
        rst = 1'b1;
        tick();
        check_idle("after_rst");

        // Randomized values, with idle gaps on phases 0..2.
        repeat (25) begin
            v = int'($urandom_range(0, 255));
            run_conv(v);
            check_scan(v, ($urandom_range(0, 1) == 0) ? 7 : 13);
            if ($urandom_range(0, 1) == 1) begin
                data_in = 8'($urandom);
                tick();
                check("rand_bcd_hold", bcd, model_bcd(v));
            end
            leave();
            phase = 2'($urandom_range(0, 2));
            repeat ($urandom_range(1, 4)) tick();
            check("gap_idle", {busy, an, seg}, 11'd0);
        end

        check("queue_drained", exp_q.size(), 0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
